// File: rtl/pipe_md_pkg.sv
// Shared definitions for the pipelined multiply/divide unit: op codes,
// controller states and the operand-width legality rule.
package pipe_md_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    // The datapath splits the accumulator into two equal halves.
    function automatic bit width_ok(input int w);
        return (w >= 4) && ((w % 2) == 0);
    endfunction

endpackage

// File: rtl/pipe_md_abs.sv
// Magnitude/sign split of one operand; unsigned operands pass through with
// the sign forced low.
module pipe_md_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             signed_i,
    output logic [WIDTH-1:0] mag_o,
    output logic             neg_o
);

    assign neg_o = signed_i & val_i[WIDTH-1];
    // The most negative value maps to 2**(WIDTH-1), which still fits unsigned.
    assign mag_o = neg_o ? -val_i : val_i;

endmodule

// File: rtl/pipe_muldiv.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per
// CALC cycle on operand magnitudes, with the sign fix-up applied in FIX.
module pipe_muldiv
    import pipe_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_by_zero_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("pipe_muldiv: WIDTH must be even and at least 4");
    end

    state_e               state_q;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q, acc_step_d;
    logic [WIDTH-1:0]     hi_q, lo_q, hi_d, lo_d;
    logic                 dbz_q, dbz_d;

    logic                 is_mul, is_signed;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 a_neg, b_neg;

    assign is_mul    = (op_q == OP_MULT) || (op_q == OP_MULTU);
    assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);

    pipe_md_abs #(.WIDTH(WIDTH)) u_abs_a (
        .val_i    (a_q),
        .signed_i (is_signed),
        .mag_o    (a_mag),
        .neg_o    (a_neg)
    );

    pipe_md_abs #(.WIDTH(WIDTH)) u_abs_b (
        .val_i    (b_q),
        .signed_i (is_signed),
        .mag_o    (b_mag),
        .neg_o    (b_neg)
    );

    // Shared adder: multiply adds the multiplicand into the upper half,
    // divide subtracts the divisor from the shifted partial remainder.
    logic [WIDTH:0]   add_x, add_y;
    logic             add_cin;
    logic [WIDTH+1:0] add_sum;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        add_x   = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        add_y   = '0;
        add_cin = 1'b0;
        if (is_mul) begin
            if (acc_q[0]) add_y = {1'b0, b_mag};
        end else begin
            add_x   = acc_q[2*WIDTH-1:WIDTH-1];
            add_y   = ~{1'b0, b_mag};
            add_cin = 1'b1;
        end
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};
    end

    always_comb begin
        acc_step_d = {acc_q[2*WIDTH-2:0], 1'b0};
        if (is_mul) begin
            acc_step_d = {add_sum[WIDTH:0], acc_q[WIDTH-1:1]};
        end else if (add_sum[WIDTH+1]) begin
            // No borrow: the divisor fits, keep the difference and set the quotient bit.
            acc_step_d = {add_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        prod_fix = acc_q;
        hi_d     = acc_q[2*WIDTH-1:WIDTH];
        lo_d     = acc_q[WIDTH-1:0];
        dbz_d    = 1'b0;
        if (is_mul) begin
            if (a_neg ^ b_neg) prod_fix = -acc_q;
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
        end else if (b_q == '0) begin
            hi_d  = a_q;
            lo_d  = '1;
            dbz_d = 1'b1;
        end else begin
            // Quotient truncates toward zero; remainder follows the dividend.
            if (a_neg)         hi_d = -acc_q[2*WIDTH-1:WIDTH];
            if (a_neg ^ b_neg) lo_d = -acc_q[WIDTH-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && !cancel_i) begin
                        state_q <= S_CALC;
                        op_q    <= op_i;
                        a_q     <= a_i;
                        b_q     <= b_i;
                        cnt_q   <= '0;
                    end
                end
                S_CALC: begin
                    if (cancel_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        // Count 0 loads the magnitudes; counts 1..WIDTH iterate.
                        if (cnt_q == '0) acc_q <= {{WIDTH{1'b0}}, a_mag};
                        else             acc_q <= acc_step_d;
                        if (cnt_q == CNT_W'(WIDTH)) state_q <= S_FIX;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_FIX: begin
                    if (cancel_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_DONE;
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        dbz_q   <= dbz_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o        = (state_q == S_CALC) || (state_q == S_FIX);
    assign done_o        = (state_q == S_DONE);
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_pipe_muldiv.sv
// Scoreboard bench for pipe_muldiv: directed corner cases plus randomized
// operations against a plain-arithmetic reference model.
module tb_pipe_muldiv;

    localparam int W = 32;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start_i = 1'b0;
    logic         cancel_i = 1'b0;
    logic [1:0]   op_i = 2'b00;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         busy_o, done_o, div_by_zero_o;
    logic [W-1:0] hi_o, lo_o;

    pipe_muldiv #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .op_i          (op_i),
        .a_i           (a_i),
        .b_i           (b_i),
        .cancel_i      (cancel_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .div_by_zero_o (div_by_zero_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           start_cyc;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dbz);
        exp_t e;
        e.hi = hi;
        e.lo = lo;
        e.dbz = dbz;
        e.start_cyc = 0;
        return e;
    endfunction

    // Reference: 64-bit integer arithmetic, SV division already truncates toward zero.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint sa, sb, q, r;
        logic [2*W-1:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e = mk('0, '0, 1'b0);
        if (op == 2'b00 || op == 2'b01) begin
            if (op == 2'b00) p = sa * sb;
            else             p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            e.hi = p[2*W-1:W];
            e.lo = p[W-1:0];
        end else if (b == '0) begin
            e = mk(a, '1, 1'b1);
        end else begin
            if (op == 2'b10) begin
                q = sa / sb;
                r = sa % sb;
            end else begin
                q = longint'({{W{1'b0}}, a}) / longint'({{W{1'b0}}, b});
                r = longint'({{W{1'b0}}, a}) % longint'({{W{1'b0}}, b});
            end
            e.hi = r[W-1:0];
            e.lo = q[W-1:0];
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    exp_t m_e;
    always @(negedge clk) begin
        if (rst && done_o) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'(sb_q.size()), 64'd1);
            end else begin
                m_e = sb_q.pop_front();
                check("hi", 64'(hi_o), 64'(m_e.hi));
                check("lo", 64'(lo_o), 64'(m_e.lo));
                check("dbz", 64'(div_by_zero_o), 64'(m_e.dbz));
                check("latency", 64'(cyc - m_e.start_cyc), 64'(LAT));
            end
        end
    end

    task automatic scramble();
        start_i = 1'b0;
        op_i = 2'($urandom);
        a_i = W'($urandom);
        b_i = W'($urandom);
    endtask

    // mode 0: plain; 1: extra start pulses in CALC and DONE; 2: cancel during DONE.
    task automatic wait_done(input int mode);
        bit seen = 1'b0;
        for (int i = 0; i < LAT + 8 && !seen; i++) begin
            @(negedge clk);
            seen = done_o;
        end
        check("done_seen", 64'(seen), 64'd1);
        if (seen && mode == 1) begin
            start_i = 1'b1;
            op_i = 2'($urandom);
            a_i = W'($urandom);
            b_i = W'($urandom);
        end
        if (seen && mode == 2) begin
            cancel_i = 1'b1;
            #1;
            check("done_under_cancel", 64'(done_o), 64'd1);
        end
        @(posedge clk);
        #1;
        start_i = 1'b0;
        cancel_i = 1'b0;
    endtask

    // Called just after a rising edge with the DUT idle; start is sampled at the next edge.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input exp_t e, input int mode);
        start_i = 1'b1;
        op_i = op;
        a_i = a;
        b_i = b;
        e.start_cyc = cyc + 1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        scramble();
        if (mode == 1) begin
            repeat (5) @(posedge clk);
            #1;
            start_i = 1'b1;
            @(posedge clk);
            #1;
            start_i = 1'b0;
        end
        wait_done(mode);
    endtask

    task automatic cancel_op(input int n, input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dbz);
        start_i = 1'b1;
        op_i = 2'b11;
        a_i = 32'd999;
        b_i = 32'd7;
        @(posedge clk);
        #1;
        scramble();
        repeat (n - 1) @(posedge clk);
        #1;
        check("busy_before_cancel", 64'(busy_o), 64'd1);
        cancel_i = 1'b1;
        @(posedge clk);
        #1;
        cancel_i = 1'b0;
        check("busy_after_cancel", 64'(busy_o), 64'd0);
        repeat (LAT + 4) @(posedge clk);
        #1;
        check("hi_kept", 64'(hi_o), 64'(hi));
        check("lo_kept", 64'(lo_o), 64'(lo));
        check("dbz_kept", 64'(div_by_zero_o), 64'(dbz));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return W'(1);
            2: return '1;
            3: return 32'h8000_0000;
            4: return 32'h7fff_ffff;
            5: return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_hi", 64'(hi_o), 64'd0);
        check("rst_lo", 64'(lo_o), 64'd0);
        check("rst_dbz", 64'(div_by_zero_o), 64'd0);

        @(posedge clk);
        #1;
        rst = 1'b1;
        issue(2'b00, 32'hFFFF_FFFD, 32'd5, mk(32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0), 0);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b0), 0);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0), 0);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h0, 32'h8000_0000, 1'b0), 0);
        issue(2'b11, 32'd100, 32'd0, mk(32'h64, 32'hFFFF_FFFF, 1'b1), 0);
        issue(2'b10, 32'hFFFF_FFFB, 32'd0, mk(32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1), 0);
        issue(2'b00, 32'h0000_1234, 32'd1, mk(32'h0, 32'h1234, 1'b0), 0);

        cancel_op(10, 32'h0, 32'h1234, 1'b0);
        issue(2'b11, 32'h0000_1234, 32'd0, mk(32'h1234, 32'hFFFF_FFFF, 1'b1), 0);
        cancel_op(LAT, 32'h1234, 32'hFFFF_FFFF, 1'b1);

        start_i = 1'b1;
        cancel_i = 1'b1;
        op_i = 2'b01;
        a_i = 32'd3;
        b_i = 32'd3;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        cancel_i = 1'b0;
        check("cancel_beats_start", 64'(busy_o), 64'd0);
        repeat (LAT + 4) @(posedge clk);
        #1;

        issue(2'b00, 32'hFFFF_FF00, 32'h0000_0300, model(2'b00, 32'hFFFF_FF00, 32'h0000_0300), 1);
        issue(2'b10, 32'd100, 32'hFFFF_FFF9, model(2'b10, 32'd100, 32'hFFFF_FFF9), 2);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra = pick();
            rb = pick();
            issue(rop, ra, rb, model(rop, ra, rb), 0);
        end

        start_i = 1'b1;
        op_i = 2'b11;
        a_i = 32'hDEAD_BEEF;
        b_i = 32'd3;
        @(posedge clk);
        #1;
        scramble();
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_done", 64'(done_o), 64'd0);
        check("midrst_hi", 64'(hi_o), 64'd0);
        check("midrst_lo", 64'(lo_o), 64'd0);
        check("midrst_dbz", 64'(div_by_zero_o), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        issue(2'b01, 32'd6, 32'd7, mk(32'd0, 32'd42, 1'b0), 0);

        repeat (LAT + 4) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
